// File: rtl/multi_ctrl.sv
// Multi-cycle MIPS-style main controller.
// One state register; next state and all datapath controls are decoded from it.
// Outputs are Moore except pc_en/ir_write/instr_done, which are qualified by
// mem_ready or zero in the states that wait on them.
module multi_ctrl #(
    parameter bit ILLEGAL_TRAP = 1'b0  // 1: unsupported opcode parks in HALT
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11,
        StHalt   = 4'd15
    } state_e;

    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    state_e state_q, state_d;
    logic   op_legal;

    // funct is decoded by the ALU control block, not here.
    logic unused_funct;
    assign unused_funct = ^funct;

    assign op_legal = (op == OpLw) || (op == OpSw) || (op == OpRtype) ||
                      (op == OpBeq) || (op == OpJ) || (op == OpAddi);

    assign state = state_q;

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExec;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiEx;
                    default:    state_d = ILLEGAL_TRAP ? StHalt : StFetch;
                endcase
            end
            StMemAdr: state_d = (op == OpLw) ? StMemRd : StMemWr;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StJump:   state_d = StFetch;
            StAddiEx: state_d = StAddiWb;
            StAddiWb: state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    // State register; reset is asynchronous so a held reset shows FETCH outputs at once.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath control decode from current state.
    always_comb begin
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // PC+4 and IR load happen only on the completing cycle of the fetch.
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            StDecode: begin
                alu_src_b = 2'b11;
                illegal   = ~op_legal;
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            StMemWr: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            StExec: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            StAluWb: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_en      = zero;
                instr_done = 1'b1;
            end
            StJump: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StAddiWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;  // HALT and unused codes drive nothing
        endcase
    end

endmodule

// File: doc/multi_ctrl.md
MULTI_CTRL -- requirements
Module: multi_ctrl

Interface
REQ-001 Parameter ILLEGAL_TRAP, default 0: 0 = unsupported opcode returns to FETCH; 1 = unsupported opcode parks in HALT until reset.
REQ-002 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 Port init_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port op, input, 6: opcode field of the current instruction register.
REQ-005 Port funct, input, 6: funct field; consulted only in the EXEC state.
REQ-006 Port zero, input, 1: ALU zero flag.
REQ-007 Port mem_ready, input, 1: memory handshake; the current access completes in a cycle where it is 1.
REQ-008 Port pc_en, output, 1: PC load enable.
REQ-009 Port pc_src, output, 2: next-PC select; 00 = ALU result, 01 = ALU register, 10 = jump target {pc[31:28],target,2'b00}.
REQ-010 Ports ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a: outputs, 1 bit each; datapath strobes and mux selects.
REQ-011 Port alu_src_b, output, 2: 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
REQ-012 Port alu_op, output, 2: 00 = add, 01 = subtract, 10 = decode funct.
REQ-013 Port instr_done, output, 1: one-cycle pulse in the final cycle of each instruction.
REQ-014 Port illegal, output, 1: one-cycle pulse in DECODE when op is unsupported.
REQ-015 Port state, output, 4: current state code, for debug.

Function
REQ-016 State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=15.
- Codes 12-14 are unused and transition to FETCH.
REQ-017 Outputs are decoded from state only (Moore), except that pc_en, ir_write and instr_done are qualified by mem_ready/zero where stated below.
- Every output not listed for a state is 0.
REQ-018 FETCH:
- Asserts mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
- ir_write=pc_en=mem_ready; holds in FETCH while mem_ready=0; moves to DECODE when mem_ready=1.
- PC therefore advances by exactly 4 once per fetch, regardless of wait cycles.
REQ-019 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by op:
- 100011 or 101011 -> MEMADR
- 000000 -> EXEC
- 000100 -> BRANCH
- 000010 -> JUMP
- 001000 -> ADDIEX
- any other op -> illegal=1; next state FETCH (ILLEGAL_TRAP=0) or HALT (ILLEGAL_TRAP=1).
REQ-020 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEMRD if op=100011, else MEMWR.
REQ-021 MEMRD: mem_read=1, i_or_d=1. Holds while mem_ready=0; moves to MEMWB on mem_ready=1.
REQ-022 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
REQ-023 MEMWR: mem_write=1, i_or_d=1. Holds while mem_ready=0; on mem_ready=1 asserts instr_done=1 and moves to FETCH.
REQ-024 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state ALUWB.
REQ-025 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
REQ-026 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero, instr_done=1. Next state FETCH.
REQ-027 JUMP: pc_src=10, pc_en=1, instr_done=1. Next state FETCH.
REQ-028 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDIWB.
REQ-029 ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state FETCH.
REQ-030 HALT: all outputs 0; stays in HALT until init_n is asserted.
REQ-031 Latency with mem_ready held at 1:
- lw = 5 cycles
- sw, R-type, addi = 4 cycles
- beq, j = 3 cycles.
- Each memory wait cycle adds one cycle.
REQ-032 mem_ready is ignored in all states other than FETCH, MEMRD and MEMWR.
REQ-033 mem_write and reg_write are never asserted in the same cycle.
REQ-034 pc_en is asserted at most once per non-FETCH instruction phase.

Reset
REQ-035 init_n=0 forces state=FETCH immediately, without waiting for a clock edge, and from any state including HALT and the wait states.
REQ-036 While init_n=0, outputs are combinationally those of FETCH with mem_ready gating.
REQ-037 No pc_en or ir_write pulse is produced on reset release unless mem_ready=1 on the first rising edge after release.
REQ-038 A reset asserted during MEMWR or MEMRD aborts the access with no completion pulse.

Verification
REQ-039 Reset, then lw (op=100011) with mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_done pulses once.
REQ-040 FETCH with mem_ready=0 for 3 cycles, then 1 -> state stays 0 for 4 cycles; pc_en and ir_write high only in the 4th cycle.
REQ-041 beq (op=000100) with zero=1, then with zero=0 -> pc_en=1 with pc_src=01 in state 8 for the first; pc_en=0 for the second.
REQ-042 j (op=000010) -> state 9 has pc_en=1 and pc_src=10; back to FETCH on the next cycle.
REQ-043 op=111111 with ILLEGAL_TRAP=0 -> illegal pulses, next state 0; with ILLEGAL_TRAP=1 -> state 15 held for 10 cycles, then init_n low -> state 0 with no clock edge required.
REQ-044 sw (op=101011) with mem_ready=0 for 2 cycles in state 5, and init_n pulsed low mid-wait -> mem_write drops immediately, state=0, and instr_done is never asserted.
